// File: rtl/wr_fram_bank_buf_pkg.sv
// Shared definitions for the write-frame bank buffer.
//   rd_state_t : read-side burst FSM states (IDLE/REQ/XFER/REL)
//   clog2      : ceiling log2 for sizing widths from parameters
package wr_fram_bank_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_REL  = 2'd3
  } rd_state_t;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/wr_fram_gray_sync.sv
// Clock-domain crossing for a binary bank pointer.
// The source pointer is converted to gray and registered in the source domain,
// passed through a two-flop synchroniser in the destination domain and
// converted back to binary there. Only one bit changes per increment, so the
// destination never sees a pointer value that was not actually held.
//   src_clk/src_rst : source domain clock, async active-high reset
//   src_bin         : pointer value the source register is about to hold
//   dst_clk/dst_rst : destination domain clock, async active-high reset
//   dst_bin         : synchronised binary pointer (destination domain)
module wr_fram_gray_sync #(
  parameter int W = 3
) (
  input  logic         src_clk,
  input  logic         src_rst,
  input  logic [W-1:0] src_bin,
  input  logic         dst_clk,
  input  logic         dst_rst,
  output logic [W-1:0] dst_bin
);

  logic [W-1:0] src_gray_reg;
  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) src_gray_reg <= '0;
    else         src_gray_reg <= src_bin ^ (src_bin >> 1);
  end

  always_ff @(posedge dst_clk or posedge dst_rst) begin
    if (dst_rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= src_gray_reg;
      sync_reg <= meta_reg;
    end
  end

  // gray->binary: each binary bit is the XOR of all gray bits at or above it
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_g2b
      assign dst_bin[gi] = ^sync_reg[W-1:gi];
    end
  endgenerate

endmodule

// File: rtl/wr_fram_bank_buf.sv
// Dual-clock multi-bank write-frame buffer.
// The write side packs RATIO narrow words into one wide memory word and
// commits a bank once BURST_LEN wide words are filled. The read side requests
// one DDR burst per committed bank, streams the words on rd_data_req and then
// releases the bank.
//   rd_clk, rd_rst     : read/DDR clock, async active-high reset
//   wr_clk, wr_rst     : write/video clock, async active-high reset
//   wr_en, wr_data     : pixel word strobe and data
//   wr_flush           : drop the partially filled bank
//   wr_full, wr_ovf    : all banks occupied / sticky write-while-full
//   burst_req/ack      : burst handshake, burst_len is constant BURST_LEN
//   rd_data_req        : pull one wide word (1-cycle latency to rd_data_valid)
//   rd_data, rd_data_valid, rd_level : read word, its strobe, banks available
module wr_fram_bank_buf
  import wr_fram_bank_buf_pkg::*;
#(
  parameter int WR_DATA_WIDTH = 32,
  parameter int RD_DATA_WIDTH = 256,
  parameter int BURST_LEN     = 64,
  parameter int NUM_BANKS     = 4
) (
  input  logic                           rd_clk,
  input  logic                           rd_rst,
  input  logic                           wr_clk,
  input  logic                           wr_rst,
  input  logic                           wr_en,
  input  logic [WR_DATA_WIDTH-1:0]       wr_data,
  input  logic                           wr_flush,
  output logic                           wr_full,
  output logic                           wr_ovf,
  output logic                           burst_req,
  output logic [clog2(BURST_LEN):0]      burst_len,
  input  logic                           burst_ack,
  input  logic                           rd_data_req,
  output logic [RD_DATA_WIDTH-1:0]       rd_data,
  output logic                           rd_data_valid,
  output logic [clog2(NUM_BANKS):0]      rd_level
);

  localparam int RATIO     = RD_DATA_WIDTH / WR_DATA_WIDTH;
  localparam int LOG_RATIO = clog2(RATIO);
  localparam int WORD_W    = clog2(BURST_LEN);
  localparam int BANK_W    = clog2(NUM_BANKS);
  localparam int PTR_W     = BANK_W + 1;
  localparam int OFF_W     = WORD_W + LOG_RATIO;
  localparam int LANE_W    = (LOG_RATIO > 0) ? LOG_RATIO : 1;
  localparam int ADDR_W    = BANK_W + WORD_W;
  localparam int DEPTH     = NUM_BANKS * BURST_LEN;
  localparam int BLEN_W    = WORD_W + 1;

  localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(BURST_LEN * RATIO - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(BURST_LEN - 1);

  assign burst_len = BLEN_W'(BURST_LEN);

  // ---------------- write domain ----------------
  logic [OFF_W-1:0]  offset_reg, offset_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_wsync;
  logic              wr_ovf_reg, wr_ovf_next;
  logic              wr_accept;
  logic [LANE_W-1:0] wr_lane;
  logic [ADDR_W-1:0] wr_addr;

  // Synchronised read pointer lags the truth, so full may linger but never
  // clears early.
  assign wr_full   = (wr_ptr_reg - rd_ptr_wsync) == PTR_W'(NUM_BANKS);
  assign wr_ovf    = wr_ovf_reg;
  assign wr_accept = wr_en && !wr_full && !wr_flush;
  assign wr_addr   = {wr_ptr_reg[BANK_W-1:0], offset_reg[OFF_W-1:LOG_RATIO]};

  generate
    if (LOG_RATIO > 0) begin : g_lane_sel
      assign wr_lane = offset_reg[LOG_RATIO-1:0];
    end else begin : g_lane_zero
      assign wr_lane = '0;
    end
  endgenerate

  always_comb begin
    offset_next = offset_reg;
    wr_ptr_next = wr_ptr_reg;
    wr_ovf_next = wr_ovf_reg;
    if (wr_flush) begin
      offset_next = '0;
    end else if (wr_en) begin
      if (wr_full) begin
        wr_ovf_next = 1'b1;
      end else begin
        // offset wraps naturally; the wrap is the bank commit
        offset_next = offset_reg + 1'b1;
        if (offset_reg == OFF_LAST) wr_ptr_next = wr_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      offset_reg <= '0;
      wr_ptr_reg <= '0;
      wr_ovf_reg <= 1'b0;
    end else begin
      offset_reg <= offset_next;
      wr_ptr_reg <= wr_ptr_next;
      wr_ovf_reg <= wr_ovf_next;
    end
  end

  // ---------------- read domain ----------------
  rd_state_t         state_reg, state_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_rsync;
  logic [WORD_W-1:0] rd_word_reg, rd_word_next;
  logic              rd_fire;
  logic              rd_data_valid_reg;
  logic [ADDR_W-1:0] rd_addr;

  assign rd_level      = wr_ptr_rsync - rd_ptr_reg;
  assign rd_addr       = {rd_ptr_reg[BANK_W-1:0], rd_word_reg};
  assign rd_data_valid = rd_data_valid_reg;

  always_comb begin
    state_next   = state_reg;
    rd_ptr_next  = rd_ptr_reg;
    rd_word_next = rd_word_reg;
    burst_req    = 1'b0;
    rd_fire      = 1'b0;
    case (state_reg)
      ST_IDLE: if (rd_level != '0) state_next = ST_REQ;
      ST_REQ: begin
        burst_req = 1'b1;
        if (burst_ack) state_next = ST_XFER;
      end
      ST_XFER: if (rd_data_req) begin
        rd_fire      = 1'b1;
        // word counter wraps to zero after the last word of the burst
        rd_word_next = rd_word_reg + 1'b1;
        if (rd_word_reg == WORD_LAST) state_next = ST_REL;
      end
      ST_REL: begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_reg         <= ST_IDLE;
      rd_ptr_reg        <= '0;
      rd_word_reg       <= '0;
      rd_data_valid_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      rd_ptr_reg        <= rd_ptr_next;
      rd_word_reg       <= rd_word_next;
      rd_data_valid_reg <= rd_fire;
    end
  end

  // ---------------- memory: one lane per packed narrow word ----------------
  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      logic [WR_DATA_WIDTH-1:0] mem [DEPTH];
      logic [WR_DATA_WIDTH-1:0] q_reg;

      always_ff @(posedge wr_clk) begin
        if (wr_accept && (wr_lane == LANE_W'(gi))) mem[wr_addr] <= wr_data;
      end

      always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst)       q_reg <= '0;
        else if (rd_fire) q_reg <= mem[rd_addr];
      end

      assign rd_data[gi*WR_DATA_WIDTH +: WR_DATA_WIDTH] = q_reg;
    end
  endgenerate

  // Pointer sync is fed the next value so the gray register tracks the
  // binary pointer without an extra cycle of latency.
  wr_fram_gray_sync #(.W(PTR_W)) u_wr2rd (
    .src_clk (wr_clk),
    .src_rst (wr_rst),
    .src_bin (wr_ptr_next),
    .dst_clk (rd_clk),
    .dst_rst (rd_rst),
    .dst_bin (wr_ptr_rsync)
  );

  wr_fram_gray_sync #(.W(PTR_W)) u_rd2wr (
    .src_clk (rd_clk),
    .src_rst (rd_rst),
    .src_bin (rd_ptr_next),
    .dst_clk (wr_clk),
    .dst_rst (wr_rst),
    .dst_bin (rd_ptr_wsync)
  );

endmodule

// File: tb/tb_wr_fram_bank_buf.sv
module tb_wr_fram_bank_buf;

  localparam int BL      = 64;
  localparam int NB      = 4;
  localparam int RATIO   = 8;
  localparam int BANK_PX = BL * RATIO;

  logic         rd_clk = 1'b0;
  logic         wr_clk = 1'b0;
  logic         rd_rst = 1'b1;
  logic         wr_rst = 1'b1;
  logic         wr_en = 1'b0;
  logic         wr_flush = 1'b0;
  logic         burst_ack = 1'b0;
  logic         rd_data_req = 1'b0;
  logic [31:0]  wr_data = '0;
  logic         wr_full, wr_ovf, burst_req, rd_data_valid;
  logic [6:0]   burst_len;
  logic [255:0] rd_data;
  logic [2:0]   rd_level;

  always #3 rd_clk = ~rd_clk;
  always #7 wr_clk = ~wr_clk;

  wr_fram_bank_buf #(
    .WR_DATA_WIDTH(32), .RD_DATA_WIDTH(256), .BURST_LEN(BL), .NUM_BANKS(NB)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .wr_clk(wr_clk), .wr_rst(wr_rst),
    .wr_en(wr_en), .wr_data(wr_data), .wr_flush(wr_flush),
    .wr_full(wr_full), .wr_ovf(wr_ovf),
    .burst_req(burst_req), .burst_len(burst_len), .burst_ack(burst_ack),
    .rd_data_req(rd_data_req), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .rd_level(rd_level)
  );

  // ---------------- behavioural model ----------------
  logic [31:0]  cur_px[$];     // pixels of the bank being filled
  logic [255:0] exp_words[$];  // committed wide words, in read order
  int           m_committed = 0;
  int           m_released  = 0;
  bit           m_in_xfer   = 1'b0;
  bit           chk_en      = 1'b0;
  bit           exp_v       = 1'b0;
  int           checks      = 0;
  int           failures    = 0;
  int           obs_cnt     = 0;
  logic [255:0] obs_first   = '0;
  logic [255:0] exp_pop;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic void model_push(input logic [31:0] d);
    logic [255:0] pk;
    if (m_committed - m_released >= NB) return;  // buffer full: word dropped
    cur_px.push_back(d);
    if (cur_px.size() == BANK_PX) begin
      for (int w = 0; w < BL; w++) begin
        pk = '0;
        for (int l = 0; l < RATIO; l++) pk[l*32 +: 32] = cur_px[w*RATIO + l];
        exp_words.push_back(pk);
      end
      cur_px.delete();
      m_committed++;
    end
  endfunction

  // a request counts only if the bench knows the burst is in transfer
  always @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) exp_v <= 1'b0;
    else        exp_v <= rd_data_req && m_in_xfer;
  end

  always @(negedge rd_clk) begin
    if (chk_en && !rd_rst) begin
      chk("rd_data_valid", {255'd0, rd_data_valid}, {255'd0, exp_v});
      if (exp_v) begin
        if (exp_words.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_data_extra actual=%0h required=none", rd_data);
        end else begin
          exp_pop = exp_words.pop_front();
          chk("rd_data", rd_data, exp_pop);
        end
        if (obs_cnt == 0) obs_first = rd_data;
        obs_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_rd(input int n);
    repeat (n) @(negedge rd_clk);
  endtask

  task automatic wait_wr(input int n);
    repeat (n) @(negedge wr_clk);
  endtask

  task automatic wr_cycle(input bit en, input logic [31:0] d, input bit fl);
    @(negedge wr_clk);
    wr_en = en; wr_data = d; wr_flush = fl;
    @(posedge wr_clk); #1;
    if (fl) cur_px.delete();
    else if (en) model_push(d);
    wr_en = 1'b0; wr_flush = 1'b0;
  endtask

  task automatic rd_burst(input int nreq, input bit gaps);
    int t;
    int n;
    t = 0;
    @(negedge rd_clk);
    while (burst_req !== 1'b1 && t < 6000) begin
      @(negedge rd_clk); t++;
    end
    if (burst_req !== 1'b1) begin
      checks++; failures++;
      $display("FAIL burst_req_timeout actual=%b required=1", burst_req);
      return;
    end
    @(negedge rd_clk);
    burst_ack = 1'b1;
    @(posedge rd_clk); #1;
    burst_ack = 1'b0;
    m_in_xfer = 1'b1;
    chk("burst_req_drop", {255'd0, burst_req}, 256'd0);
    n = 0;
    while (n < nreq) begin
      @(negedge rd_clk);
      if (gaps && $urandom_range(0, 3) == 0) rd_data_req = 1'b0;
      else begin rd_data_req = 1'b1; n++; end
      @(posedge rd_clk); #1;
      rd_data_req = 1'b0;
    end
    m_in_xfer = 1'b0;
    if (nreq == BL) m_released++;
    $display("burst done: %0d requests, committed=%0d released=%0d", nreq, m_committed, m_released);
  endtask

  task automatic stray_reqs(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge rd_clk); rd_data_req = 1'b1;
      @(posedge rd_clk); #1; rd_data_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rd_data_req = 1'b0; burst_ack = 1'b0; wr_en = 1'b0; wr_flush = 1'b0;
    rd_rst = 1'b1; wr_rst = 1'b1;
    repeat (4) @(posedge wr_clk);
    #1;
    cur_px.delete(); exp_words.delete();
    m_committed = 0; m_released = 0; m_in_xfer = 1'b0;
    chk("rst_wr_full",   {255'd0, wr_full},       256'd0);
    chk("rst_wr_ovf",    {255'd0, wr_ovf},        256'd0);
    chk("rst_burst_req", {255'd0, burst_req},     256'd0);
    chk("rst_rd_valid",  {255'd0, rd_data_valid}, 256'd0);
    chk("rst_rd_data",   rd_data,                 256'd0);
    chk("rst_rd_level",  {253'd0, rd_level},      256'd0);
    @(negedge wr_clk);
    rd_rst = 1'b0; wr_rst = 1'b0;
    wait_rd(2);
    chk_en = 1'b1;
    obs_cnt = 0;
    $display("reset done");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int g;
    do_reset();
    chk("burst_len", {249'd0, burst_len}, 256'd64);

    // one bank of 0..511, burst_req must follow quickly
    for (int i = 0; i < BANK_PX; i++) wr_cycle(1'b1, 32'(i), 1'b0);
    t = 0;
    @(negedge rd_clk);
    while (burst_req !== 1'b1 && t < 6) begin @(negedge rd_clk); t++; end
    chk("burst_req_rise", {255'd0, burst_req}, 256'd1);
    chk("rd_level_one", {253'd0, rd_level}, 256'd1);
    obs_cnt = 0;
    rd_burst(BL, 1'b0);
    wait_rd(3);
    chk("t1_word0_lane0", {224'd0, obs_first[31:0]},    256'd0);
    chk("t1_word0_lane7", {224'd0, obs_first[255:224]}, 256'd7);
    chk("t1_words_seen",  256'(obs_cnt), 256'd64);
    chk("t1_rd_level",    {253'd0, rd_level}, 256'd0);

    // two banks, back-to-back pulls, stray requests after the last word
    for (int i = 0; i < 2 * BANK_PX; i++) wr_cycle(1'b1, 32'h1000_0000 + 32'(i), 1'b0);
    wait_rd(12);
    chk("t2_rd_level_two", {253'd0, rd_level}, 256'd2);
    rd_burst(BL, 1'b0);
    stray_reqs(3);
    wait_rd(2);
    chk("t2_rd_level_dec", {253'd0, rd_level}, 256'd1);
    chk("t2_burst_req_held", {255'd0, burst_req}, 256'd1);
    rd_burst(BL, 1'b1);
    wait_rd(4);
    chk("t2_rd_level_zero", {253'd0, rd_level}, 256'd0);

    // partial bank flushed (flush beats a simultaneous write)
    for (int i = 0; i < 100; i++) wr_cycle(1'b1, 32'h2000_0000 + 32'(i), 1'b0);
    wr_cycle(1'b1, 32'hDEAD_BEEF, 1'b1);
    for (int i = 0; i < BANK_PX; i++) wr_cycle(1'b1, 32'h3000_0000 + 32'(i), 1'b0);
    wait_rd(12);
    chk("t3_one_bank", {253'd0, rd_level}, 256'd1);
    obs_cnt = 0;
    rd_burst(BL, 1'b0);
    wait_rd(12);
    chk("t3_lane0", {224'd0, obs_first[31:0]},  256'h3000_0000);
    chk("t3_lane1", {224'd0, obs_first[63:32]}, 256'h3000_0001);
    chk("t3_no_second_burst", {255'd0, burst_req}, 256'd0);

    // fill every bank, overflow, then drain one
    for (int i = 0; i < NB * BANK_PX; i++) wr_cycle(1'b1, 32'h4000_0000 + 32'(i), 1'b0);
    wait_wr(8);
    chk("t4_full", {255'd0, wr_full}, 256'd1);
    chk("t4_no_ovf_yet", {255'd0, wr_ovf}, 256'd0);
    chk("t4_rd_level_four", {253'd0, rd_level}, 256'd4);
    wr_cycle(1'b1, 32'hBAD0_0001, 1'b0);
    wait_wr(1);
    chk("t4_ovf", {255'd0, wr_ovf}, 256'd1);
    rd_burst(BL, 1'b0);
    t = 0;
    while (wr_full === 1'b1 && t < 4) begin @(negedge wr_clk); t++; end
    chk("t4_full_clears", {255'd0, wr_full}, 256'd0);
    chk("t4_ovf_sticky", {255'd0, wr_ovf}, 256'd1);
    for (int b = 0; b < NB - 1; b++) rd_burst(BL, 1'b0);
    wait_rd(4);

    // reset in the middle of a transfer
    for (int i = 0; i < BANK_PX; i++) wr_cycle(1'b1, 32'h5000_0000 + 32'(i), 1'b0);
    rd_burst(30, 1'b0);
    wait_rd(2);
    do_reset();
    for (int i = 0; i < BANK_PX; i++) wr_cycle(1'b1, 32'h6000_0000 + 32'(i), 1'b0);
    obs_cnt = 0;
    rd_burst(BL, 1'b0);
    wait_rd(3);
    chk("t5_after_reset_lane0", {224'd0, obs_first[31:0]}, 256'h6000_0000);
    chk("t5_words_seen", 256'(obs_cnt), 256'd64);

    // concurrent streaming with random gaps on both sides
    fork
      begin
        for (int b = 0; b < 12; b++) begin
          g = 0;
          while (m_committed - m_released >= NB && g < 20000) begin @(posedge wr_clk); g++; end
          if (g >= 20000) begin
            checks++; failures++;
            $display("FAIL writer_stall actual=%0d required=<%0d", m_committed - m_released, NB);
          end
          if (g > 0) wait_wr(8);
          for (int i = 0; i < BANK_PX; i++) begin
            if ($urandom_range(0, 3) == 0) wr_cycle(1'b0, 32'd0, 1'b0);
            wr_cycle(1'b1, $urandom(), 1'b0);
          end
        end
      end
      begin
        for (int b = 0; b < 12; b++) rd_burst(BL, 1'b1);
      end
    join
    wait_rd(6);
    chk("t6_no_ovf", {255'd0, wr_ovf}, 256'd0);
    chk("t6_all_read", 256'(exp_words.size()), 256'd0);
    chk("t6_rd_level", {253'd0, rd_level}, 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
